// File: rtl/regfile_pkg.sv
// Shared defaults, log2 helper and CSR index constants for the register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

    localparam int unsigned CSR_TOHOST = 0;
    localparam int unsigned CSR_STATUS = 1;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: busy bits, per-read-port busy flags and pending count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS    = NREGS_DEFAULT,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned NWR      = 2,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned AW       = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NRD*AW-1:0] raddr,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_rd,
    output logic [NRD-1:0]    rbusy,
    output logic [AW:0]       busy_cnt
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_d;

    // Next busy vector: writes clear, issue sets afterwards so it wins; count is its popcount.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wen[w]) busy_d[waddr[w*AW +: AW]] = 1'b0;
        end
        if (issue_en) busy_d[issue_rd] = 1'b1;
        if (ZERO_REG) busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Busy bits and pending count update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
        end
    end

    // A register being written this cycle is reported ready to its readers.
    always_comb begin
        rbusy = '0;
        for (int p = 0; p < NRD; p++) begin
            rbusy[p] = reset_n & busy_q[raddr[p*AW +: AW]];
            for (int w = 0; w < NWR; w++) begin
                if (wen[w] && (waddr[w*AW +: AW] == raddr[p*AW +: AW])) rbusy[p] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-first bypass, CSR bank and pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN     = XLEN_DEFAULT,
    parameter  int unsigned NREGS    = NREGS_DEFAULT,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned NWR      = 2,
    parameter  int unsigned NCSR     = 4,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned AW       = clog2(NREGS),
    localparam int unsigned CW       = (clog2(NCSR) > 0) ? clog2(NCSR) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    output logic [AW:0]         busy_cnt,
    input  logic                csr_we,
    input  logic [CW-1:0]       csr_waddr,
    input  logic [XLEN-1:0]     csr_wdata,
    input  logic [CW-1:0]       csr_raddr,
    output logic [XLEN-1:0]     csr_rdata
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] csr_q  [NCSR];
    logic            csr_wr_ok;
    logic            csr_rd_ok;

    // Later write ports are applied last so the highest index wins; writes to x0 dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wen[w] && !(ZERO_REG && (waddr[w*AW +: AW] == '0))) begin
                    regs_q[waddr[w*AW +: AW]] <= wdata[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Combinational read with write-first bypass in the same port priority order.
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            rdata[p*XLEN +: XLEN] = regs_q[raddr[p*AW +: AW]];
            for (int w = 0; w < NWR; w++) begin
                if (wen[w] && (waddr[w*AW +: AW] == raddr[p*AW +: AW])) begin
                    rdata[p*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG && (raddr[p*AW +: AW] == '0)) || !reset_n) begin
                rdata[p*XLEN +: XLEN] = '0;
            end
        end
    end

    assign csr_wr_ok = csr_we && ({1'b0, csr_waddr} < (CW+1)'(NCSR));
    assign csr_rd_ok = ({1'b0, csr_raddr} < (CW+1)'(NCSR));

    // CSR bank; out-of-range indices are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCSR; i++) csr_q[i] <= '0;
        end else if (csr_wr_ok) begin
            csr_q[csr_waddr] <= csr_wdata;
        end
    end

    // CSR read with same-cycle bypass; out-of-range and reset read as zero.
    always_comb begin
        csr_rdata = '0;
        if (reset_n && csr_rd_ok) begin
            if (csr_wr_ok && (csr_waddr == csr_raddr)) csr_rdata = csr_wdata;
            else                                       csr_rdata = csr_q[csr_raddr];
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .raddr    (raddr),
        .wen      (wen),
        .waddr    (waddr),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .rbusy    (rbusy),
        .busy_cnt (busy_cnt)
    );

endmodule
